frogger_game_ctrl: RTL and testbench
====================================

Name: frogger_game_ctrl

Overview:
- Game-flow sequencer for the Frogger datapath. It decides when play is active, when the frog respawns, and when score, lives and level change.
- It also generates the per-level lane-advance strobe that drives car/log motion.
- It sits between the playfield/collision logic (frog position, hit, pad-reached flags) and the video/score blocks.
- It owns score, replacing the score register currently held in the frog controller.

Parameters:
c_START_LIVES, 3, lives loaded at game start (1..3)
c_SCORE_LIMIT, 99, score at which the game ends as a win
c_PADS_PER_LEVEL, 5, successful crossings per level increment
c_MAX_LEVEL, 7, level saturation value
c_DEATH_FRAMES, 60, frames spent in the death animation
c_SCORE_FRAMES, 30, frames spent in the pad celebration
c_BASE_PERIOD, 16, frames per lane step at level 0
c_PERIOD_STEP, 2, period reduction per level (period floor = 1)

Ports:
i_Clk  in  1  pixel clock (25 MHz)
i_Rst  in  1  asynchronous active-high reset
i_VSync  in  1  vertical sync already aligned to i_Clk; rising edge = frame boundary
i_Game_Start  in  1  start button, level, debounced upstream
i_Frog_Hit  in  1  frog on road vehicle or in water this cycle
i_Pad_Reached  in  1  frog occupies a lily-pad tile
o_Game_Active  out  1  high only in PLAY
o_Frog_Respawn  out  1  one-cycle pulse: return frog to start tile
o_Lane_Step  out  1  one-cycle pulse: lanes advance one tile
o_Score  out  7  crossings completed (0..c_SCORE_LIMIT)
o_Lives  out  2  remaining lives
o_Level  out  3  current difficulty level
o_State  out  3  IDLE=0, PLAY=1, DYING=2, SCORED=3, OVER=4

Behaviour:
- Reset (asynchronous) forces:
  - State: IDLE.
  - Outputs: all outputs 0 except o_Lives = c_START_LIVES.
  - Internals: frame counter 0, lane counter 0, pad counter 0.
- Frame tick: registered edge detect on i_VSync. The tick is high for exactly one cycle, the cycle after i_VSync is first seen high.
- Start edge: registered edge detect on i_Game_Start. Holding the button never retriggers.
- IDLE and OVER:
  - o_Game_Active = 0.
  - On start edge: go to PLAY; load score=0, lives=c_START_LIVES, level=0, pad counter=0; pulse o_Frog_Respawn in the same cycle as the transition.
- PLAY:
  - o_Game_Active = 1.
  - i_Frog_Hit takes priority over i_Pad_Reached when both are high in the same cycle.
  - On hit: lives -= 1 (no underflow; lives ≥1 is guaranteed in PLAY); go to DYING; clear frame counter.
  - On pad:
    - score += 1, saturating at c_SCORE_LIMIT.
    - pad counter += 1. When it reaches c_PADS_PER_LEVEL it returns to 0 and level += 1, saturating at c_MAX_LEVEL.
    - Go to SCORED; clear frame counter.
- DYING:
  - o_Game_Active = 0.
  - Count frame ticks. On the tick that brings the count to c_DEATH_FRAMES:
    - lives == 0: go to OVER.
    - otherwise: pulse o_Frog_Respawn and go to PLAY.
- SCORED:
  - o_Game_Active = 0.
  - After c_SCORE_FRAMES ticks:
    - score == c_SCORE_LIMIT: go to OVER.
    - otherwise: respawn pulse and go to PLAY.
- Lane strobe:
  - period = max(1, c_BASE_PERIOD − c_PERIOD_STEP·level).
  - The lane counter increments only on frame ticks in PLAY.
  - When it equals period−1: it wraps to 0 and o_Lane_Step pulses in that tick cycle.
  - The counter is cleared on any exit from PLAY.
  - A level change mid-count uses the new period from the next tick. If the count is already ≥ new period−1, it wraps on the next tick.
- Hit/pad inputs are ignored outside PLAY.
- Reset asserted mid-animation aborts immediately to IDLE; no respawn pulse is issued.

Decomposition:
- Package frogger_pkg holds:
  - state encoding constants;
  - score, lives and level widths;
  - c_GAME_HEIGHT / c_GAME_WIDTH, shared with the playfield.
- One sub-module, frogger_frame_timer:
  - VSync edge detect producing the frame tick;
  - loadable frame-tick down-counter with a done flag, used by DYING and SCORED.
- The lane counter stays in the top FSM.

Test Plan:
Bench settings for all cases: c_DEATH_FRAMES=4, c_SCORE_FRAMES=2, c_BASE_PERIOD=4.
- Reset, then start edge -> o_State=1, o_Score=0, o_Lives=3, o_Level=0, one o_Frog_Respawn pulse; holding start 100 cycles gives no further pulse.
- PLAY, 12 frames, no events -> o_Lane_Step pulses on ticks 4, 8, 12 only, each one cycle wide.
- Hit and pad high in the same cycle -> DYING, lives 3→2, score unchanged; 4 ticks later a respawn pulse and PLAY.
- Three hits -> after the third death animation o_State=4, o_Lives=0, o_Game_Active=0; start edge -> PLAY, lives=3, score=0.
- Five pad events -> score=5, level=1, lane period now 2 ticks; with c_SCORE_LIMIT=5 the fifth pad ends in OVER after 2 ticks.
- i_Rst asserted asynchronously (between clock edges) during DYING -> outputs immediately IDLE/reset values, no respawn pulse.

Source files
------------

// File: rtl/frogger_pkg.sv
// Shared types and widths for the Frogger game-flow logic and the playfield.
package frogger_pkg;

  // Game-flow state encoding, also exported on o_State.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PLAY   = 3'd1,
    ST_DYING  = 3'd2,
    ST_SCORED = 3'd3,
    ST_OVER   = 3'd4
  } state_t;

  localparam int c_SCORE_W = 7;
  localparam int c_LIVES_W = 2;
  localparam int c_LEVEL_W = 3;
  localparam int c_CNT_W   = 8;   // frame timer, lane and pad counters

  // Playfield size in tiles, shared with the playfield/collision logic.
  localparam int c_GAME_WIDTH  = 14;
  localparam int c_GAME_HEIGHT = 13;

  // Frames per lane step at a given level, never below one frame.
  function automatic logic [c_CNT_W-1:0] lane_period(input int base,
                                                      input int step,
                                                      input logic [c_LEVEL_W-1:0] level);
    int p;
    p = base - step * int'(level);
    if (p < 1) p = 1;
    return c_CNT_W'(p);
  endfunction

endpackage

// File: rtl/frogger_frame_timer.sv
// Frame tick generator from VSync plus a loadable frame-tick down-counter
// used to time the death and celebration animations.
module frogger_frame_timer
  import frogger_pkg::*;
(
  input  logic               i_Clk,
  input  logic               i_Rst,
  input  logic               i_VSync,
  input  logic               i_Load,
  input  logic [c_CNT_W-1:0] i_Load_Val,
  output logic               o_Tick,
  output logic               o_Done
);

  logic               r_vsync_d;
  logic               r_tick;
  logic [c_CNT_W-1:0] r_count;

  // Registered rising-edge detect: one tick the cycle after VSync is first seen high.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    if (i_Rst) begin
      r_vsync_d <= 1'b0;
      r_tick    <= 1'b0;
    end else begin
      r_vsync_d <= i_VSync;
      r_tick    <= i_VSync & ~r_vsync_d;
    end
  end

  // Animation counter: load wins over counting; counts ticks down to zero.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_count <= '0;
    end else if (i_Load) begin
      r_count <= i_Load_Val;
    end else if (r_tick && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_Tick = r_tick;
  // Done marks the tick that consumes the last remaining frame.
  assign o_Done = r_tick && (r_count == c_CNT_W'(1));

endmodule

// File: rtl/frogger_game_ctrl.sv
// Frogger game-flow sequencer: play/death/celebration flow, score, lives,
// level and the per-level lane-advance strobe.
module frogger_game_ctrl
  import frogger_pkg::*;
#(
  parameter int c_START_LIVES    = 3,
  parameter int c_SCORE_LIMIT    = 99,
  parameter int c_PADS_PER_LEVEL = 5,
  parameter int c_MAX_LEVEL      = 7,
  parameter int c_DEATH_FRAMES   = 60,
  parameter int c_SCORE_FRAMES   = 30,
  parameter int c_BASE_PERIOD    = 16,
  parameter int c_PERIOD_STEP    = 2
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_VSync,
  input  logic       i_Game_Start,
  input  logic       i_Frog_Hit,
  input  logic       i_Pad_Reached,
  output logic       o_Game_Active,
  output logic       o_Frog_Respawn,
  output logic       o_Lane_Step,
  output logic [6:0] o_Score,
  output logic [1:0] o_Lives,
  output logic [2:0] o_Level,
  output logic [2:0] o_State
);

  localparam logic [c_SCORE_W-1:0] c_SCORE_MAX = c_SCORE_W'(c_SCORE_LIMIT);
  localparam logic [c_LIVES_W-1:0] c_LIVES_INI = c_LIVES_W'(c_START_LIVES);
  localparam logic [c_LEVEL_W-1:0] c_LEVEL_MAX = c_LEVEL_W'(c_MAX_LEVEL);
  localparam logic [c_CNT_W-1:0]   c_PAD_LAST  = c_CNT_W'(c_PADS_PER_LEVEL - 1);

  state_t               r_state;
  state_t               w_next_state;
  logic                 r_start_d;
  logic                 r_start_edge;
  logic [c_SCORE_W-1:0] r_score;
  logic [c_LIVES_W-1:0] r_lives;
  logic [c_LEVEL_W-1:0] r_level;
  logic [c_CNT_W-1:0]   r_pad_cnt;
  logic [c_CNT_W-1:0]   r_lane_cnt;

  logic               w_tick;
  logic               w_timer_done;
  logic               w_timer_load;
  logic [c_CNT_W-1:0] w_timer_val;
  logic               w_active;
  logic               w_respawn;
  logic               w_new_game;
  logic               w_hit;
  logic               w_pad;
  logic [c_CNT_W-1:0] w_period;
  logic               w_lane_wrap;
  logic               w_lane_step;

  frogger_frame_timer u_frame_timer (
    .i_Clk      (i_Clk),
    .i_Rst      (i_Rst),
    .i_VSync    (i_VSync),
    .i_Load     (w_timer_load),
    .i_Load_Val (w_timer_val),
    .o_Tick     (w_tick),
    .o_Done     (w_timer_done)
  );

  // Start-button edge detect so a held button never restarts the game.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_start_d    <= 1'b0;
      r_start_edge <= 1'b0;
    end else begin
      r_start_d    <= i_Game_Start;
      r_start_edge <= i_Game_Start & ~r_start_d;
    end
  end

  // State register.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) r_state <= ST_IDLE;
    else       r_state <= w_next_state;
  end

  // Next-state and control decode; hit outranks pad in PLAY.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned
    // and no latch is inferred.
    w_next_state = r_state;
    w_active     = 1'b0;
    w_respawn    = 1'b0;
    w_new_game   = 1'b0;
    w_hit        = 1'b0;
    w_pad        = 1'b0;
    w_timer_load = 1'b0;
    w_timer_val  = '0;
    case (r_state)
      ST_IDLE, ST_OVER: begin
        if (r_start_edge) begin
          w_next_state = ST_PLAY;
          w_new_game   = 1'b1;
          w_respawn    = 1'b1;
        end
      end
      ST_PLAY: begin
        w_active = 1'b1;
        if (i_Frog_Hit) begin
          w_hit        = 1'b1;
          w_next_state = ST_DYING;
          w_timer_load = 1'b1;
          w_timer_val  = c_CNT_W'(c_DEATH_FRAMES);
        end else if (i_Pad_Reached) begin
          w_pad        = 1'b1;
          w_next_state = ST_SCORED;
          w_timer_load = 1'b1;
          w_timer_val  = c_CNT_W'(c_SCORE_FRAMES);
        end
      end
      ST_DYING: begin
        if (w_timer_done) begin
          if (r_lives == '0) begin
            w_next_state = ST_OVER;
          end else begin
            w_next_state = ST_PLAY;
            w_respawn    = 1'b1;
          end
        end
      end
      ST_SCORED: begin
        if (w_timer_done) begin
          if (r_score == c_SCORE_MAX) begin
            w_next_state = ST_OVER;
          end else begin
            w_next_state = ST_PLAY;
            w_respawn    = 1'b1;
          end
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Lane period follows the current level; a count already past the new
  // period wraps on the next tick.
  assign w_period    = lane_period(c_BASE_PERIOD, c_PERIOD_STEP, r_level);
  assign w_lane_wrap = (r_lane_cnt >= (w_period - 1'b1));
  assign w_lane_step = (r_state == ST_PLAY) && w_tick && w_lane_wrap;

  // Score, lives, level and pad bookkeeping.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_score   <= '0;
      r_lives   <= c_LIVES_INI;
      r_level   <= '0;
      r_pad_cnt <= '0;
    end else if (w_new_game) begin
      r_score   <= '0;
      r_lives   <= c_LIVES_INI;
      r_level   <= '0;
      r_pad_cnt <= '0;
    end else if (w_hit) begin
      if (r_lives != '0) r_lives <= r_lives - 1'b1;
    end else if (w_pad) begin
      if (r_score < c_SCORE_MAX) r_score <= r_score + 1'b1;
      if (r_pad_cnt >= c_PAD_LAST) begin
        r_pad_cnt <= '0;
        if (r_level < c_LEVEL_MAX) r_level <= r_level + 1'b1;
      end else begin
        r_pad_cnt <= r_pad_cnt + 1'b1;
      end
    end
  end

  // Lane counter: counts ticks only while staying in PLAY, cleared otherwise.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_lane_cnt <= '0;
    end else if (w_next_state != ST_PLAY) begin
      r_lane_cnt <= '0;
    end else if ((r_state == ST_PLAY) && w_tick) begin
      r_lane_cnt <= w_lane_wrap ? '0 : r_lane_cnt + 1'b1;
    end
  end

  assign o_Game_Active  = w_active;
  assign o_Frog_Respawn = w_respawn;
  assign o_Lane_Step    = w_lane_step;
  assign o_Score        = r_score;
  assign o_Lives        = r_lives;
  assign o_Level        = r_level;
  assign o_State        = r_state;

endmodule

// File: tb/tb_frogger_game_ctrl.sv
// Directed self-checking bench for frogger_game_ctrl. A second instance with
// a score limit of 5 shares the stimulus to exercise the winning end of game.
module tb_frogger_game_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic vsync = 1'b0;
  logic start = 1'b0;
  logic hit = 1'b0;
  logic pad = 1'b0;

  logic       active, respawn, lane_step;
  logic [6:0] score;
  logic [1:0] lives;
  logic [2:0] level, state;

  logic       d2_active, d2_respawn, d2_lane_step;
  logic [6:0] d2_score;
  logic [1:0] d2_lives;
  logic [2:0] d2_level, d2_state;

  int n_tests = 0;
  int n_fail  = 0;
  int n_resp  = 0;
  int n_lane  = 0;
  int snap;

  always #5 clk = ~clk;

  frogger_game_ctrl #(
    .c_DEATH_FRAMES (4),
    .c_SCORE_FRAMES (2),
    .c_BASE_PERIOD  (4)
  ) dut (
    .i_Clk          (clk),
    .i_Rst          (rst),
    .i_VSync        (vsync),
    .i_Game_Start   (start),
    .i_Frog_Hit     (hit),
    .i_Pad_Reached  (pad),
    .o_Game_Active  (active),
    .o_Frog_Respawn (respawn),
    .o_Lane_Step    (lane_step),
    .o_Score        (score),
    .o_Lives        (lives),
    .o_Level        (level),
    .o_State        (state)
  );

  frogger_game_ctrl #(
    .c_SCORE_LIMIT  (5),
    .c_DEATH_FRAMES (4),
    .c_SCORE_FRAMES (2),
    .c_BASE_PERIOD  (4)
  ) dut2 (
    .i_Clk          (clk),
    .i_Rst          (rst),
    .i_VSync        (vsync),
    .i_Game_Start   (start),
    .i_Frog_Hit     (hit),
    .i_Pad_Reached  (pad),
    .o_Game_Active  (d2_active),
    .o_Frog_Respawn (d2_respawn),
    .o_Lane_Step    (d2_lane_step),
    .o_Score        (d2_score),
    .o_Lives        (d2_lives),
    .o_Level        (d2_level),
    .o_State        (d2_state)
  );

  // Pulse counters sampled mid-cycle; a one-cycle pulse counts exactly once.
  always @(negedge clk) begin
    if (respawn === 1'b1)   n_resp++;
    if (lane_step === 1'b1) n_lane++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance n clock edges; inputs change 2 time units after each edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // One video frame: VSync high for two cycles, low for three.
  task automatic frame();
    vsync = 1'b1;
    step(2);
    vsync = 1'b0;
    step(3);
  endtask

  task automatic pulse_event(input logic h, input logic p);
    hit = h;
    pad = p;
    step(1);
    hit = 1'b0;
    pad = 1'b0;
  endtask

  initial begin
    // Reset values while reset is held.
    step(3);
    @(negedge clk);
    check("rst_state", state, 0);
    check("rst_score", score, 0);
    check("rst_lives", lives, 3);
    check("rst_level", level, 0);
    check("rst_active", active, 0);
    check("rst_respawn", respawn, 0);
    check("rst_lane", lane_step, 0);
    step(1);
    rst = 1'b0;
    step(2);

    // Start edge, button held for 100 cycles: exactly one respawn.
    snap = n_resp;
    start = 1'b1;
    step(100);
    @(negedge clk);
    check("start_state", state, 1);
    check("start_active", active, 1);
    check("start_score", score, 0);
    check("start_lives", lives, 3);
    check("start_level", level, 0);
    check("start_resp_once", n_resp - snap, 1);
    start = 1'b0;
    step(1);

    // Twelve quiet frames at period 4: lane steps on ticks 4, 8, 12.
    for (int f = 1; f <= 12; f++) begin
      snap = n_lane;
      frame();
      check($sformatf("lane_l0_tick%0d", f), n_lane - snap, (f % 4 == 0) ? 1 : 0);
    end

    // Hit and pad together: hit wins.
    pulse_event(1'b1, 1'b1);
    @(negedge clk);
    check("hp_state", state, 2);
    check("hp_lives", lives, 2);
    check("hp_score", score, 0);
    check("hp_active", active, 0);
    snap = n_resp;
    frame(); frame(); frame();
    check("dying_3ticks_state", state, 2);
    check("dying_3ticks_resp", n_resp - snap, 0);
    frame();
    check("dying_end_state", state, 1);
    check("dying_end_resp", n_resp - snap, 1);

    // Second and third hits: game over with no respawn.
    pulse_event(1'b1, 1'b0);
    frame(); frame(); frame(); frame();
    check("hit2_state", state, 1);
    check("hit2_lives", lives, 1);
    pulse_event(1'b1, 1'b0);
    snap = n_resp;
    frame(); frame(); frame(); frame();
    @(negedge clk);
    check("over_state", state, 4);
    check("over_lives", lives, 0);
    check("over_active", active, 0);
    check("over_no_resp", n_resp - snap, 0);

    // Restart from OVER.
    snap = n_resp;
    start = 1'b1;
    step(3);
    start = 1'b0;
    @(negedge clk);
    check("restart_state", state, 1);
    check("restart_lives", lives, 3);
    check("restart_score", score, 0);
    check("restart_resp", n_resp - snap, 1);
    step(1);

    // Five crossings: score 5, level 1; limit-5 instance ends the game.
    for (int k = 1; k <= 4; k++) begin
      pulse_event(1'b0, 1'b1);
      frame(); frame();
      check($sformatf("pad%0d_score", k), score, k);
      check($sformatf("pad%0d_state", k), state, 1);
    end
    check("pad4_level", level, 0);
    pulse_event(1'b0, 1'b1);
    @(negedge clk);
    check("pad5_state", state, 3);
    check("pad5_score", score, 5);
    check("pad5_level", level, 1);
    check("lim_pad5_score", d2_score, 5);
    snap = n_resp;
    frame();
    check("pad5_1tick_state", state, 3);
    frame();
    check("pad5_end_state", state, 1);
    check("pad5_end_resp", n_resp - snap, 1);
    check("lim_over_state", d2_state, 4);
    check("lim_over_active", d2_active, 0);

    // Level 1 lane period is 2 ticks.
    for (int f = 1; f <= 4; f++) begin
      snap = n_lane;
      frame();
      check($sformatf("lane_l1_tick%0d", f), n_lane - snap, (f % 2 == 0) ? 1 : 0);
    end

    // Asynchronous reset in the middle of the death animation.
    pulse_event(1'b1, 1'b0);
    frame();
    @(negedge clk);
    check("pre_rst_state", state, 2);
    snap = n_resp;
    #2;
    rst = 1'b1;
    #1;
    check("arst_state", state, 0);
    check("arst_score", score, 0);
    check("arst_lives", lives, 3);
    check("arst_level", level, 0);
    check("arst_active", active, 0);
    check("arst_respawn", respawn, 0);
    step(3);
    rst = 1'b0;
    frame(); frame(); frame(); frame(); frame();
    check("arst_no_resp", n_resp - snap, 0);
    check("arst_stay_idle", state, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
